// File: rtl/regbus_arb_pkg.sv
// Shared types and the round-robin search helper for the REGBUS arbiter.
// The optional ACCESS timeout is enabled with the REGBUS_ARB_TIMEOUT_EN macro.
package regbus_arb_pkg;

  // Widest requester vector the picker handles.
  localparam int unsigned RrMaxReq    = 8;
  localparam int unsigned RegbusAddrW = 32;
  localparam int unsigned RegbusDataW = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } arb_state_e;

  // One REGBUS request at the default bus widths.
  typedef struct packed {
    logic [RegbusAddrW-1:0] addr;
    logic                   write;
    logic [RegbusDataW-1:0] wdata;
  } regbus_req_t;

  // Round-robin search starting just after 'last'. Returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [RrMaxReq-1:0] req,
                                         input logic [2:0]          last,
                                         input int unsigned         num);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int unsigned k = 1; k <= num; k++) begin
      idx = 3'((32'(last) + k) % num);
      if (!res[3] && req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: request vector plus previous winner in,
// one-hot grant and winner index out.
module rr_grant
  import regbus_arb_pkg::*;
#(
  parameter  int unsigned NumReq = 4,
  localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   last_grant_i,
  output logic [NumReq-1:0] grant_o,
  output logic [IdxW-1:0]   grant_idx_o,
  output logic              grant_valid_o
);

  logic [3:0] pick;

  // Search from last_grant+1 and decode the winner to one-hot.
  always_comb begin
    pick          = rr_pick(RrMaxReq'(req_i), 3'(last_grant_i), NumReq);
    grant_valid_o = pick[3];
    grant_idx_o   = IdxW'(pick[2:0]);
    grant_o       = '0;
    if (pick[3]) begin
      grant_o[grant_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/regbus_rr_arbiter.sv
// Round-robin arbiter sharing one REGBUS target between NUM_REQ requesters.
// Define REGBUS_ARB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYC cycles.
module regbus_rr_arbiter
  import regbus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                      pclk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      timeout_evt,
  output logic [ADDR_W-1:0]         m_paddr,
  output logic                      m_pwrite,
  output logic [DATA_W-1:0]         m_pwdata,
  output logic                      m_psel,
  output logic                      m_penable,
  input  logic                      m_pready,
  input  logic [DATA_W-1:0]         m_prdata,
  input  logic                      m_pslverr
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state_q, state_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [IdxW-1:0]     gidx_q, gidx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_slverr_q, rsp_slverr_d;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_valid;

`ifdef REGBUS_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0]     to_cnt_q, to_cnt_d;
  logic                to_evt_q, to_evt_d;
`endif

  rr_grant #(
    .NumReq (NUM_REQ)
  ) u_rr_grant (
    .req_i         (req_valid),
    .last_grant_i  (last_q),
    .grant_o       (pick_grant),
    .grant_idx_o   (pick_idx),
    .grant_valid_o (pick_valid)
  );

  // Grant/latch in IDLE, sequence SETUP/ACCESS, and form the next-cycle response.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gidx_d       = gidx_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = '0;
    rsp_slverr_d = 1'b0;
    req_ready    = '0;
`ifdef REGBUS_ARB_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    to_evt_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          req_ready = pick_grant;
          last_d    = pick_idx;
          gidx_d    = pick_idx;
          addr_d    = req_addr[pick_idx*ADDR_W +: ADDR_W];
          write_d   = req_write[pick_idx];
          wdata_d   = req_wdata[pick_idx*DATA_W +: DATA_W];
          state_d   = SETUP;
`ifdef REGBUS_ARB_TIMEOUT_EN
          to_cnt_d  = '0;
`endif
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (m_pready) begin
          state_d             = IDLE;
          rsp_valid_d[gidx_q] = 1'b1;
          rsp_rdata_d         = write_q ? '0 : m_prdata;
          rsp_slverr_d        = m_pslverr;
        end
`ifdef REGBUS_ARB_TIMEOUT_EN
        else begin
          to_cnt_d = to_cnt_q + CntW'(1);
          if (to_cnt_d == CntW'(TIMEOUT_CYC)) begin
            // Abort: report as an error with no read data.
            state_d             = IDLE;
            rsp_valid_d[gidx_q] = 1'b1;
            rsp_slverr_d        = 1'b1;
            to_evt_d            = 1'b1;
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and registered response.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= IdxW'(NUM_REQ - 1);
      gidx_q       <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gidx_q       <= gidx_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_slverr_q <= rsp_slverr_d;
    end
  end

`ifdef REGBUS_ARB_TIMEOUT_EN
  // Wait-state counter and abort flag.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      to_evt_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_evt_q <= to_evt_d;
    end
  end

  assign timeout_evt = to_evt_q;
`else
  assign timeout_evt = 1'b0;
`endif

  // psel/penable decode straight from state so reset drops them immediately.
  always_comb begin
    m_psel     = (state_q != IDLE);
    m_penable  = (state_q == ACCESS);
    m_paddr    = addr_q;
    m_pwrite   = write_q;
    m_pwdata   = wdata_q;
    rsp_valid  = rsp_valid_q;
    rsp_rdata  = rsp_rdata_q;
    rsp_slverr = rsp_slverr_q;
  end

endmodule
